sdma_addr_gen: RTL
==================

# sdma_addr_gen

SDMA address generator: downstream consumer of the 32-bit SDMA system address register. It loads the programmed system address on transfer start and steps it one 32-bit word per data-path acknowledge. It counts bytes and blocks and pauses with an interrupt pulse at each SDMA buffer boundary until the host rewrites the address register. Its `busy` output drives the register's `busy_in`, so the address cannot be overwritten mid-run.

## Interface
- `ADDR_W`, 32, system address width
- `BLK_W`, 16, block counter width
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0)
- `sysadd`  in  ADDR_W  current contents of the system address register
- `sysadd_wr`  in  1  one-cycle pulse: host completed a write to the address register
- `start`  in  1  one-cycle pulse: begin transfer
- `bnd_sel`  in  3  buffer boundary = 4 KiB << `bnd_sel` (4 KiB..512 KiB)
- `blk_size`  in  12  bytes per block, 0..2048
- `blk_cnt`  in  BLK_W  number of blocks
- `word_ack`  in  1  data path consumed one word at `addr` this cycle
- `addr`  out  ADDR_W  current word address, bits [1:0] always 0
- `addr_valid`  out  1  `addr` may be used by the data path
- `busy`  out  1  high in RUN only; connects to register `busy_in`
- `dma_int`  out  1  one-cycle pulse: buffer boundary reached
- `xfer_done`  out  1  one-cycle pulse: last word of last block acknowledged

## Operation
- States: IDLE, RUN, BND_WAIT, DONE.
- IDLE: `start` latches `addr` = {`sysadd`[31:2],2'b00}, `byte_cnt` = 0, `blk_left` = `blk_cnt`, then goes to RUN. If `blk_cnt` = 0 or `blk_size` = 0, goes to DONE instead.
- RUN, `word_ack`: `addr` += 4 (modulo 2^ADDR_W; wraps 0xFFFFFFFC→0), `byte_cnt` += 4.
- End of block: when `byte_cnt` + 4 ≥ `blk_size`, `byte_cnt` clears and `blk_left` decrements. A `blk_size` that is not a multiple of 4 rounds up.
- After the last block's last word → DONE.
- Boundary: the incremented `addr` has zero bits below log2(4096 << `bnd_sel`) and the transfer is not finished → BND_WAIT.
- Boundary and completion in the same ack: completion wins. No `dma_int` is raised.
- BND_WAIT: `addr_valid` low, `word_ack` ignored. `sysadd_wr` reloads `addr` = {`sysadd`[31:2],2'b00} → RUN. Counters are preserved.
- DONE: lasts one cycle, then → IDLE.
- `start` outside IDLE is ignored. `sysadd_wr` outside BND_WAIT is ignored.
- `blk_size`, `blk_cnt`, `bnd_sel` are sampled continuously. Software keeps them stable while not IDLE.

## Timing
- Reset (`rst`=0, any state, including mid-transfer): IDLE; `addr`=0, `addr_valid`=0, `busy`=0, `dma_int`=0, `xfer_done`=0; counters 0. This is immediate and does not wait for the clock.
- `start` in cycle N → RUN, `addr_valid`=1, `busy`=1 from cycle N+1.
- `word_ack` in cycle N → new `addr` visible in cycle N+1. Back-to-back acks are allowed every cycle.
- `dma_int` is high for exactly the first cycle of BND_WAIT. `addr_valid` and `busy` are 0 in that same cycle.
- `sysadd_wr` in cycle N during BND_WAIT → RUN with the new `addr` in cycle N+1.
- `xfer_done` is high during the DONE cycle. `addr_valid`=0 and `busy`=0 in DONE.
- Every output is registered.

## Configuration
- `SDMA_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort`=1 in RUN or BND_WAIT → IDLE next cycle.
  - No `xfer_done`, no `dma_int`; `addr` holds its last value.
  - `abort` takes priority over `word_ack` and `sysadd_wr` in the same cycle.
- Undefined: no `abort` port. A transfer ends only by completion or reset.

## Structure
- Shared package `sdma_pkg`:
  - state enum
  - `WORD_BYTES` = 4
  - `BND_BASE` = 4096
  - boundary mask function of `bnd_sel`
- One sub-module, `sdma_blk_counter`:
  - holds `byte_cnt` and `blk_left`
  - inputs: load, step
  - outputs: `blk_end` and `last_word`, combinational from current count and `blk_size`
- The FSM and address register stay in the top level.

## Test plan
- Reset mid-run: assert `rst`=0 with `addr`=0x1008 in RUN → all outputs 0 and IDLE without a clock edge; release, `start` → reloads from `sysadd`.
- Simple transfer: `sysadd`=0x0000_1000, `blk_size`=8, `blk_cnt`=2, `bnd_sel`=0, 4 consecutive acks → `addr` 0x1000, 0x1004, 0x1008, 0x100C; `xfer_done` one cycle after 4th ack; `busy` low after.
- Boundary: `sysadd`=0x0000_0FF8, `blk_size`=512, `blk_cnt`=1, 2 acks → `dma_int` pulse, `addr_valid`=0. Extra `word_ack` ignored. `sysadd_wr` with 0x0002_0000 → resumes at 0x0002_0000; done after 126 more acks.
- Simultaneous boundary and completion: `sysadd`=0x0000_0FFC, `blk_size`=4, `blk_cnt`=1, 1 ack → `xfer_done`=1, `dma_int` never asserted.
- Zero-length and misalignment: `blk_cnt`=0, `start` → `xfer_done` in cycle N+1, no `addr_valid`. `sysadd`=0x0000_0003 → `addr`=0.
- Wrap: `sysadd`=0xFFFF_FFFC, `bnd_sel`=7, 2-word block → `addr` wraps to 0. `dma_int` fires because 0 is boundary-aligned, unless the same ack completes the transfer. Exercise both cases.

Source files
------------

// File: rtl/sdma_pkg.sv
// -----------------------------------------------------------------------------
// sdma_pkg
// Shared definitions for the SDMA address generator:
//   - sdma_state_e : controller states
//   - WORD_BYTES   : bytes moved per data-path acknowledge
//   - BND_BASE     : smallest SDMA buffer boundary (4 KiB)
//   - BND_BITS     : address bits covered by the largest boundary (512 KiB)
//   - bnd_mask()   : low-address mask for the boundary selected by bnd_sel
// -----------------------------------------------------------------------------
package sdma_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    BND_WAIT = 2'd2,
    DONE     = 2'd3
  } sdma_state_e;

  localparam int WORD_BYTES = 4;
  localparam int BND_BASE   = 4096;
  localparam int BND_BITS   = 19;   // 4 KiB << 7 = 2^19

  // Mask of the address bits that must all be zero at a buffer boundary.
  function automatic logic [BND_BITS-1:0] bnd_mask(input logic [2:0] sel);
    logic [BND_BITS:0] span;
    span = (BND_BITS+1)'(BND_BASE) << sel;
    span = span - (BND_BITS+1)'(1);
    return span[BND_BITS-1:0];
  endfunction

endpackage

// File: rtl/sdma_blk_counter.sv
// -----------------------------------------------------------------------------
// sdma_blk_counter
// Tracks the byte offset inside the current block and the number of blocks
// still to move. A block ends on the word whose end reaches or passes
// blk_size, so sizes that are not a multiple of 4 round up to a whole word.
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   load       restart counting: byte_cnt = 0, blk_left = blk_cnt
//   step       one word consumed
//   blk_size   bytes per block (0..2048)
//   blk_cnt    number of blocks in the transfer
//   blk_end    current word is the last word of its block (combinational)
//   last_word  current word is the last word of the last block (combinational)
// -----------------------------------------------------------------------------
module sdma_blk_counter
  import sdma_pkg::*;
#(
  parameter int BLK_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [11:0]      blk_size,
  input  logic [BLK_W-1:0] blk_cnt,
  output logic             blk_end,
  output logic             last_word
);

  logic [11:0]      byte_cnt;
  logic [BLK_W-1:0] blk_left;
  logic [12:0]      byte_nxt;

  // One extra bit so byte_cnt + 4 cannot wrap before the compare.
  assign byte_nxt  = {1'b0, byte_cnt} + 13'(WORD_BYTES);
  assign blk_end   = byte_nxt >= {1'b0, blk_size};
  assign last_word = blk_end && (blk_left == BLK_W'(1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      blk_left <= '0;
    end else if (load) begin
      byte_cnt <= '0;
      blk_left <= blk_cnt;
    end else if (step) begin
      if (blk_end) begin
        byte_cnt <= '0;
        blk_left <= blk_left - BLK_W'(1);
      end else begin
        byte_cnt <= byte_nxt[11:0];
      end
    end
  end

endmodule

// File: rtl/sdma_addr_gen.sv
// -----------------------------------------------------------------------------
// sdma_addr_gen
// SDMA address generator. Loads the system address on start, steps it one
// 32-bit word per word_ack, and pauses at each SDMA buffer boundary until the
// host rewrites the address register (sysadd_wr). busy feeds the register's
// busy_in so the address cannot be overwritten mid-run.
//
// Optional feature: define SDMA_ABORT_EN to add the `abort` input, which
// returns RUN or BND_WAIT to IDLE with no interrupt and no completion pulse.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   sysadd       current system address register contents
//   sysadd_wr    host completed a write to the address register (pulse)
//   start        begin transfer (pulse, honoured in IDLE only)
//   bnd_sel      buffer boundary = 4 KiB << bnd_sel
//   blk_size     bytes per block
//   blk_cnt      number of blocks
//   word_ack     data path consumed the word at addr
//   abort        (SDMA_ABORT_EN only) cancel the transfer
//   addr         current word address, bits [1:0] always 0
//   addr_valid   addr usable by the data path (RUN)
//   busy         transfer running (RUN)
//   dma_int      first cycle of a boundary pause (pulse)
//   xfer_done    transfer complete (pulse, DONE state)
// All outputs are registered.
// -----------------------------------------------------------------------------
module sdma_addr_gen
  import sdma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sysadd,
  input  logic              sysadd_wr,
  input  logic              start,
  input  logic [2:0]        bnd_sel,
  input  logic [11:0]       blk_size,
  input  logic [BLK_W-1:0]  blk_cnt,
  input  logic              word_ack,
`ifdef SDMA_ABORT_EN
  input  logic              abort,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              busy,
  output logic              dma_int,
  output logic              xfer_done
);

  sdma_state_e       state_q, state_d;
  logic              abort_w;
  logic [ADDR_W-1:0] addr_load, addr_inc, addr_d;
  logic [BND_BITS-1:0] bnd_m;
  logic              at_bnd, zero_len, finish;
  logic              load, step, blk_end, last_word;
  logic              valid_d, busy_d, dma_d, done_d;

`ifdef SDMA_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign addr_load = {sysadd[ADDR_W-1:2], 2'b00};
  assign addr_inc  = addr + ADDR_W'(WORD_BYTES);   // wraps modulo 2^ADDR_W
  assign bnd_m     = bnd_mask(bnd_sel);
  assign at_bnd    = (addr_inc[BND_BITS-1:0] & bnd_m) == '0;
  assign zero_len  = (blk_cnt == '0) || (blk_size == '0);
  assign finish    = blk_end && last_word;

  assign load = (state_q == IDLE) && start;
  assign step = (state_q == RUN) && word_ack && !abort_w;

  sdma_blk_counter #(.BLK_W(BLK_W)) u_blk_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .blk_size  (blk_size),
    .blk_cnt   (blk_cnt),
    .blk_end   (blk_end),
    .last_word (last_word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. Completion is tested before the boundary so an ack that
  // both finishes the transfer and lands on a boundary goes straight to DONE.
  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = zero_len ? DONE : RUN;
      end
      RUN: begin
        if (abort_w)       state_d = IDLE;
        else if (word_ack) begin
          if (finish)      state_d = DONE;
          else if (at_bnd) state_d = BND_WAIT;
        end
      end
      BND_WAIT: begin
        if (abort_w)        state_d = IDLE;
        else if (sysadd_wr) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, decoded from the
  // upcoming state so each output lines up with the state it describes.
  always_comb begin
    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN);
    dma_d   = (state_q == RUN) && (state_d == BND_WAIT);
    done_d  = (state_d == DONE);
    addr_d  = addr;
    if (load)
      addr_d = addr_load;
    else if (step)
      addr_d = addr_inc;
    else if ((state_q == BND_WAIT) && sysadd_wr && !abort_w)
      addr_d = addr_load;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr       <= '0;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      dma_int    <= 1'b0;
      xfer_done  <= 1'b0;
    end else begin
      addr       <= addr_d;
      addr_valid <= valid_d;
      busy       <= busy_d;
      dma_int    <= dma_d;
      xfer_done  <= done_d;
    end
  end

endmodule
